// File: rtl/pong_game_ctrl.sv
// Pong game controller: per-frame paddle, ball, score and game-flow sequencing.
// Updates commit on the falling edge of vsync; start_i is honoured every cycle.
//
// Ports:
//   clk_i, rst_i          pixel clock, synchronous active-high reset
//   vga_vs_i              VGA vsync (active low), frame tick source
//   btn_up_i, btn_down_i  player paddle controls (level)
//   start_i               start / restart (level)
//   player_paddle_x_o/y_o player paddle top-left
//   pc_paddle_x_o/y_o     PC paddle top-left
//   ball_x_o, ball_y_o    ball top-left
//   player_score_o        player points
//   pc_score_o            PC points
//   state_o               IDLE=0 SERVE=1 PLAY=2 POINT=3 GAME_OVER=4
module pong_game_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int PADDLE_W   = 8,
    parameter int PADDLE_H   = 64,
    parameter int BALL_SIDE  = 8,
    parameter int PLAYER_X   = 16,
    parameter int PADDLE_SPD = 4,
    parameter int PC_SPD     = 3,
    parameter int BALL_SPD   = 2,
    parameter int SERVE_FRM  = 60,
    parameter int WIN_SCORE  = 7
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           vga_vs_i,
    input  logic           btn_up_i,
    input  logic           btn_down_i,
    input  logic           start_i,
    output logic [X_W-1:0] player_paddle_x_o,
    output logic [Y_W-1:0] player_paddle_y_o,
    output logic [X_W-1:0] pc_paddle_x_o,
    output logic [Y_W-1:0] pc_paddle_y_o,
    output logic [X_W-1:0] ball_x_o,
    output logic [Y_W-1:0] ball_y_o,
    output logic [3:0]     player_score_o,
    output logic [3:0]     pc_score_o,
    output logic [2:0]     state_o
);

    localparam int PC_X  = H_RES - PLAYER_X - PADDLE_W;
    localparam int CNT_W = $clog2(SERVE_FRM + 1);
    localparam int W     = ((X_W > Y_W) ? X_W : Y_W) + 2;

    typedef logic [W-1:0] wide_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam wide_t W_H_RES   = wide_t'(H_RES);
    localparam wide_t W_V_RES   = wide_t'(V_RES);
    localparam wide_t W_PAD_W   = wide_t'(PADDLE_W);
    localparam wide_t W_PAD_H   = wide_t'(PADDLE_H);
    localparam wide_t W_BALL    = wide_t'(BALL_SIDE);
    localparam wide_t W_PSPD    = wide_t'(PADDLE_SPD);
    localparam wide_t W_CSPD    = wide_t'(PC_SPD);
    localparam wide_t W_BSPD    = wide_t'(BALL_SPD);
    localparam wide_t W_PLX     = wide_t'(PLAYER_X);
    localparam wide_t W_PCX     = wide_t'(PC_X);
    localparam wide_t W_PAD_MAX = wide_t'(V_RES - PADDLE_H);
    localparam wide_t W_HPAD    = wide_t'(PADDLE_H / 2);
    localparam wide_t W_HBALL   = wide_t'(BALL_SIDE / 2);

    localparam logic [X_W-1:0]   BALL_X0   = X_W'(H_RES / 2 - BALL_SIDE / 2);
    localparam logic [Y_W-1:0]   BALL_Y0   = Y_W'(V_RES / 2 - BALL_SIDE / 2);
    localparam logic [Y_W-1:0]   PAD_Y0    = Y_W'(V_RES / 2 - PADDLE_H / 2);
    localparam logic [CNT_W-1:0] SERVE_CNT = CNT_W'(SERVE_FRM);
    localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic             vs_q;
    logic [X_W-1:0]   ball_x_q, ball_x_d;
    logic [Y_W-1:0]   ball_y_q, ball_y_d;
    logic             dir_x_q, dir_x_d;   // 1: moving +x (right)
    logic             dir_y_q, dir_y_d;   // 1: moving +y (down)
    logic [Y_W-1:0]   player_y_q, player_y_d;
    logic [Y_W-1:0]   pc_y_q, pc_y_d;
    logic [3:0]       player_score_q, player_score_d;
    logic [3:0]       pc_score_q, pc_score_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic tick;
    assign tick = vs_q & ~vga_vs_i;

    // Candidate per-frame motion, applied only by the FSM when allowed
    wide_t          py_w, pcy_w, bx_w, by_w;
    wide_t          py_n, pcy_n, bx_n, by_n;
    wide_t          pc_c, ball_c;
    logic [Y_W-1:0] player_y_mv, pc_y_mv, ball_y_mv;
    logic [X_W-1:0] ball_x_mv;
    logic           dir_x_mv, dir_y_mv;
    logic           hit_pl, hit_pc, miss_pl, miss_pc;

    always_comb begin
        py_w   = wide_t'(player_y_q);
        pcy_w  = wide_t'(pc_y_q);
        bx_w   = wide_t'(ball_x_q);
        by_w   = wide_t'(ball_y_q);
        py_n   = py_w;
        pcy_n  = pcy_w;
        bx_n   = bx_w;
        by_n   = by_w;
        dir_x_mv = dir_x_q;
        dir_y_mv = dir_y_q;
        miss_pl  = 1'b0;
        miss_pc  = 1'b0;

        if (btn_up_i && !btn_down_i) begin
            py_n = (py_w < W_PSPD) ? '0 : py_w - W_PSPD;
        end else if (btn_down_i && !btn_up_i) begin
            py_n = (py_w + W_PSPD > W_PAD_MAX) ? W_PAD_MAX : py_w + W_PSPD;
        end

        // PC paddle chases the ball centre
        pc_c   = pcy_w + W_HPAD;
        ball_c = by_w + W_HBALL;
        if (pc_c < ball_c) begin
            pcy_n = (pcy_w + W_CSPD > W_PAD_MAX) ? W_PAD_MAX : pcy_w + W_CSPD;
        end else if (pc_c > ball_c) begin
            pcy_n = (pcy_w < W_CSPD) ? '0 : pcy_w - W_CSPD;
        end

        if (!dir_y_q) begin
            if (by_w < W_BSPD) begin
                by_n     = '0;
                dir_y_mv = 1'b1;
            end else begin
                by_n = by_w - W_BSPD;
            end
        end else begin
            if (by_w + W_BALL + W_BSPD > W_V_RES) begin
                by_n     = W_V_RES - W_BALL;
                dir_y_mv = 1'b0;
            end else begin
                by_n = by_w + W_BSPD;
            end
        end

        // x-BALL_SPD <= edge rewritten as x <= edge+BALL_SPD to avoid underflow
        hit_pl = (bx_w <= W_PLX + W_PAD_W + W_BSPD) && (bx_w >= W_PLX) &&
                 (by_w + W_BALL > py_w) && (by_w < py_w + W_PAD_H);
        hit_pc = (bx_w + W_BALL + W_BSPD >= W_PCX) &&
                 (bx_w + W_BALL <= W_PCX + W_PAD_W) &&
                 (by_w + W_BALL > pcy_w) && (by_w < pcy_w + W_PAD_H);

        if (!dir_x_q) begin
            if (hit_pl) begin
                bx_n     = W_PLX + W_PAD_W;
                dir_x_mv = 1'b1;
            end else if (bx_w < W_BSPD) begin
                miss_pl = 1'b1;
            end else begin
                bx_n = bx_w - W_BSPD;
            end
        end else begin
            if (hit_pc) begin
                bx_n     = W_PCX - W_BALL;
                dir_x_mv = 1'b0;
            end else if (bx_w + W_BALL + W_BSPD > W_H_RES) begin
                miss_pc = 1'b1;
            end else begin
                bx_n = bx_w + W_BSPD;
            end
        end

        player_y_mv = py_n[Y_W-1:0];
        pc_y_mv     = pcy_n[Y_W-1:0];
        ball_x_mv   = bx_n[X_W-1:0];
        ball_y_mv   = by_n[Y_W-1:0];
    end

    always_comb begin
        state_d        = state_q;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        player_y_d     = player_y_q;
        pc_y_d         = pc_y_q;
        player_score_d = player_score_q;
        pc_score_d     = pc_score_q;
        cnt_d          = cnt_q;

        unique case (state_q)
            IDLE, GAME_OVER: begin
                if (start_i) begin
                    state_d        = SERVE;
                    player_score_d = '0;
                    pc_score_d     = '0;
                    cnt_d          = SERVE_CNT;
                    player_y_d     = PAD_Y0;
                    pc_y_d         = PAD_Y0;
                    ball_x_d       = BALL_X0;
                    ball_y_d       = BALL_Y0;
                end
            end
            SERVE: begin
                if (tick) begin
                    player_y_d = player_y_mv;
                    pc_y_d     = pc_y_mv;
                    ball_x_d   = BALL_X0;
                    ball_y_d   = BALL_Y0;
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    player_y_d = player_y_mv;
                    pc_y_d     = pc_y_mv;
                    ball_y_d   = ball_y_mv;
                    dir_y_d    = dir_y_mv;
                    // On a miss dir_x already points at the loser's side
                    if (miss_pl) begin
                        pc_score_d = pc_score_q + 4'd1;
                        state_d    = POINT;
                    end else if (miss_pc) begin
                        player_score_d = player_score_q + 4'd1;
                        state_d        = POINT;
                    end else begin
                        ball_x_d = ball_x_mv;
                        dir_x_d  = dir_x_mv;
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    cnt_d    = SERVE_CNT;
                    if (player_score_q == WIN || pc_score_q == WIN) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            vs_q           <= 1'b1;
            ball_x_q       <= BALL_X0;
            ball_y_q       <= BALL_Y0;
            dir_x_q        <= 1'b1;
            dir_y_q        <= 1'b1;
            player_y_q     <= PAD_Y0;
            pc_y_q         <= PAD_Y0;
            player_score_q <= '0;
            pc_score_q     <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            vs_q           <= vga_vs_i;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            player_y_q     <= player_y_d;
            pc_y_q         <= pc_y_d;
            player_score_q <= player_score_d;
            pc_score_q     <= pc_score_d;
            cnt_q          <= cnt_d;
        end
    end

    assign player_paddle_x_o = X_W'(PLAYER_X);
    assign pc_paddle_x_o     = X_W'(PC_X);
    assign player_paddle_y_o = player_y_q;
    assign pc_paddle_y_o     = pc_y_q;
    assign ball_x_o          = ball_x_q;
    assign ball_y_o          = ball_y_q;
    assign player_score_o    = player_score_q;
    assign pc_score_o        = pc_score_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl.
// Frame ticks are single-cycle low pulses on vga_vs_i.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs;
    logic       up;
    logic       dn;
    logic       start;
    logic [9:0] pl_x, pl_y, pc_x, pc_y, bx, by;
    logic [3:0] pl_sc, pc_sc;
    logic [2:0] st;

    int vec_cnt = 0;
    int err_cnt = 0;

    pong_game_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .vga_vs_i          (vs),
        .btn_up_i          (up),
        .btn_down_i        (dn),
        .start_i           (start),
        .player_paddle_x_o (pl_x),
        .player_paddle_y_o (pl_y),
        .pc_paddle_x_o     (pc_x),
        .pc_paddle_y_o     (pc_y),
        .ball_x_o          (bx),
        .ball_y_o          (by),
        .player_score_o    (pl_sc),
        .pc_score_o        (pc_sc),
        .state_o           (st)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; vs = 1'b1; up = 1'b0; dn = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); vs = 1'b0;
        @(negedge clk); vs = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic go_play();
        do_reset();
        press_start();
        ticks(60);
    endtask

    task automatic test_reset();
        do_reset();
        ticks(3);
        vec_cnt++; if (st !== 3'd0) begin err_cnt++; $display("FAIL rst_state got %0d exp 0", st); end
        vec_cnt++; if (bx !== 10'd316) begin err_cnt++; $display("FAIL rst_ball_x got %0d exp 316", bx); end
        vec_cnt++; if (by !== 10'd236) begin err_cnt++; $display("FAIL rst_ball_y got %0d exp 236", by); end
        vec_cnt++; if (pl_y !== 10'd208) begin err_cnt++; $display("FAIL rst_pl_y got %0d exp 208", pl_y); end
        vec_cnt++; if (pc_y !== 10'd208) begin err_cnt++; $display("FAIL rst_pc_y got %0d exp 208", pc_y); end
        vec_cnt++; if (pl_sc !== 4'd0 || pc_sc !== 4'd0) begin err_cnt++; $display("FAIL rst_scores got %0d/%0d exp 0/0", pl_sc, pc_sc); end
        vec_cnt++; if (pl_x !== 10'd16) begin err_cnt++; $display("FAIL pl_x got %0d exp 16", pl_x); end
        vec_cnt++; if (pc_x !== 10'd616) begin err_cnt++; $display("FAIL pc_x got %0d exp 616", pc_x); end
    endtask

    task automatic test_serve();
        do_reset();
        press_start();
        vec_cnt++; if (st !== 3'd1) begin err_cnt++; $display("FAIL start_state got %0d exp 1", st); end
        ticks(59);
        vec_cnt++; if (st !== 3'd1) begin err_cnt++; $display("FAIL serve59_state got %0d exp 1", st); end
        tick();
        vec_cnt++; if (st !== 3'd2) begin err_cnt++; $display("FAIL serve60_state got %0d exp 2", st); end
        vec_cnt++; if (bx !== 10'd316 || by !== 10'd236) begin err_cnt++; $display("FAIL serve_ball got %0d,%0d exp 316,236", bx, by); end
        tick();
        vec_cnt++; if (bx !== 10'd318 || by !== 10'd238) begin err_cnt++; $display("FAIL play1_ball got %0d,%0d exp 318,238", bx, by); end
    endtask

    task automatic test_paddle();
        do_reset();
        press_start();
        up = 1'b1;
        ticks(51);
        vec_cnt++; if (pl_y !== 10'd4) begin err_cnt++; $display("FAIL up51 got %0d exp 4", pl_y); end
        ticks(2);
        vec_cnt++; if (pl_y !== 10'd0) begin err_cnt++; $display("FAIL up_clamp got %0d exp 0", pl_y); end
        dn = 1'b1;
        tick();
        vec_cnt++; if (pl_y !== 10'd0) begin err_cnt++; $display("FAIL both0 got %0d exp 0", pl_y); end
        up = 1'b0;
        tick();
        vec_cnt++; if (pl_y !== 10'd4) begin err_cnt++; $display("FAIL down1 got %0d exp 4", pl_y); end
        up = 1'b1;
        tick();
        vec_cnt++; if (pl_y !== 10'd4) begin err_cnt++; $display("FAIL both4 got %0d exp 4", pl_y); end
        up = 1'b0;
        @(negedge clk);
        force dut.player_y_q = 10'd412;
        #1;
        release dut.player_y_q;
        tick();
        vec_cnt++; if (pl_y !== 10'd416) begin err_cnt++; $display("FAIL down_max got %0d exp 416", pl_y); end
        tick();
        vec_cnt++; if (pl_y !== 10'd416) begin err_cnt++; $display("FAIL down_clamp got %0d exp 416", pl_y); end
        dn = 1'b0;
        vec_cnt++; if (st !== 3'd1) begin err_cnt++; $display("FAIL paddle_state got %0d exp 1", st); end
    endtask

    task automatic test_wall();
        go_play();
        @(negedge clk);
        force dut.ball_y_q = 10'd1;
        force dut.dir_y_q = 1'b0;
        #1;
        release dut.ball_y_q;
        release dut.dir_y_q;
        tick();
        vec_cnt++; if (by !== 10'd0) begin err_cnt++; $display("FAIL top_hit got %0d exp 0", by); end
        vec_cnt++; if (pc_y !== 10'd205) begin err_cnt++; $display("FAIL pc_up got %0d exp 205", pc_y); end
        tick();
        vec_cnt++; if (by !== 10'd2) begin err_cnt++; $display("FAIL top_bounce got %0d exp 2", by); end
        @(negedge clk);
        force dut.ball_y_q = 10'd471;
        #1;
        release dut.ball_y_q;
        tick();
        vec_cnt++; if (by !== 10'd472) begin err_cnt++; $display("FAIL bot_hit got %0d exp 472", by); end
        tick();
        vec_cnt++; if (by !== 10'd470) begin err_cnt++; $display("FAIL bot_bounce got %0d exp 470", by); end
    endtask

    task automatic test_paddle_hit_miss();
        go_play();
        @(negedge clk);
        force dut.ball_x_q = 10'd25;
        force dut.dir_x_q = 1'b0;
        force dut.ball_y_q = 10'd220;
        force dut.dir_y_q = 1'b1;
        force dut.player_y_q = 10'd200;
        #1;
        release dut.ball_x_q; release dut.dir_x_q;
        release dut.ball_y_q; release dut.dir_y_q;
        release dut.player_y_q;
        tick();
        vec_cnt++; if (bx !== 10'd24) begin err_cnt++; $display("FAIL pl_hit_x got %0d exp 24", bx); end
        tick();
        vec_cnt++; if (bx !== 10'd26) begin err_cnt++; $display("FAIL pl_hit_dir got %0d exp 26", bx); end
        @(negedge clk);
        force dut.ball_x_q = 10'd25;
        force dut.dir_x_q = 1'b0;
        force dut.ball_y_q = 10'd220;
        force dut.player_y_q = 10'd0;
        #1;
        release dut.ball_x_q; release dut.dir_x_q;
        release dut.ball_y_q; release dut.player_y_q;
        ticks(12);
        vec_cnt++; if (bx !== 10'd1 || st !== 3'd2) begin err_cnt++; $display("FAIL miss_run got x=%0d st=%0d exp x=1 st=2", bx, st); end
        tick();
        vec_cnt++; if (st !== 3'd3) begin err_cnt++; $display("FAIL miss_state got %0d exp 3", st); end
        vec_cnt++; if (pc_sc !== 4'd1 || pl_sc !== 4'd0) begin err_cnt++; $display("FAIL miss_score got %0d/%0d exp 0/1", pl_sc, pc_sc); end
        tick();
        vec_cnt++; if (st !== 3'd1) begin err_cnt++; $display("FAIL point_state got %0d exp 1", st); end
        vec_cnt++; if (bx !== 10'd316 || by !== 10'd236) begin err_cnt++; $display("FAIL point_ball got %0d,%0d exp 316,236", bx, by); end
        ticks(60);
        vec_cnt++; if (st !== 3'd2) begin err_cnt++; $display("FAIL reserve_state got %0d exp 2", st); end
        tick();
        vec_cnt++; if (bx !== 10'd314 || by !== 10'd238) begin err_cnt++; $display("FAIL reserve_ball got %0d,%0d exp 314,238", bx, by); end
    endtask

    task automatic test_game_over();
        go_play();
        @(negedge clk);
        force dut.pc_score_q = 4'd6;
        force dut.ball_x_q = 10'd1;
        force dut.dir_x_q = 1'b0;
        #1;
        release dut.pc_score_q; release dut.ball_x_q; release dut.dir_x_q;
        tick();
        vec_cnt++; if (pc_sc !== 4'd7 || st !== 3'd3) begin err_cnt++; $display("FAIL win_pt got sc=%0d st=%0d exp sc=7 st=3", pc_sc, st); end
        tick();
        vec_cnt++; if (st !== 3'd4) begin err_cnt++; $display("FAIL game_over got %0d exp 4", st); end
        up = 1'b1;
        tick();
        up = 1'b0;
        vec_cnt++; if (st !== 3'd4 || pc_sc !== 4'd7 || pl_y !== 10'd208) begin err_cnt++; $display("FAIL go_frozen got st=%0d sc=%0d y=%0d exp 4,7,208", st, pc_sc, pl_y); end
        press_start();
        vec_cnt++; if (st !== 3'd1) begin err_cnt++; $display("FAIL restart_state got %0d exp 1", st); end
        vec_cnt++; if (pc_sc !== 4'd0 || pl_sc !== 4'd0) begin err_cnt++; $display("FAIL restart_scores got %0d/%0d exp 0/0", pl_sc, pc_sc); end
        vec_cnt++; if (pc_y !== 10'd208 || pl_y !== 10'd208) begin err_cnt++; $display("FAIL restart_pads got %0d/%0d exp 208/208", pl_y, pc_y); end
    endtask

    task automatic test_back_to_back();
        go_play();
        @(negedge clk);
        force dut.ball_x_q = 10'd631;
        force dut.dir_x_q = 1'b1;
        force dut.ball_y_q = 10'd300;
        force dut.pc_y_q = 10'd0;
        #1;
        release dut.ball_x_q; release dut.dir_x_q;
        release dut.ball_y_q; release dut.pc_y_q;
        tick();
        vec_cnt++; if (pl_sc !== 4'd1 || st !== 3'd3) begin err_cnt++; $display("FAIL pl_point got sc=%0d st=%0d exp 1,3", pl_sc, st); end
        tick();
        ticks(61);
        vec_cnt++; if (bx !== 10'd318) begin err_cnt++; $display("FAIL pl_point_dir got %0d exp 318", bx); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        vec_cnt++; if (st !== 3'd0 || pl_sc !== 4'd0 || bx !== 10'd316 || by !== 10'd236 || pc_y !== 10'd208) begin
            err_cnt++; $display("FAIL mid_reset got st=%0d sc=%0d ball=%0d,%0d pc=%0d", st, pl_sc, bx, by, pc_y);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle();
        test_wall();
        test_paddle_hit_miss();
        test_game_over();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
